// File: rtl/seq_controller.sv
// VeriRISC eight-state sequencing controller with memory wait states,
// stall timeout, resumable halt and illegal-opcode detection.
module seq_controller #(
  parameter int OPC_W    = 3,
  parameter bit WAIT_EN  = 1'b1,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             data_e,
  output logic             halt,
  output logic             phase,
  output logic [3:0]       state,
  output logic             err_timeout,
  output logic             err_illegal
);

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_t;

  state_t     st;
  logic [7:0] cnt;
  logic       to_q;
  logic       il_q;

  logic       illegal;
  logic [2:0] op;
  logic       is_hlt;
  logic       is_skz;
  logic       is_sto;
  logic       is_jmp;
  logic       aluop;
  logic       access;
  logic       stall;
  state_t     nxt;

  // Widened opcodes decode as HLT when any bit above [2:0] is set.
  assign illegal = |(opcode >> 3);
  assign op      = illegal ? 3'b000 : opcode[2:0];
  assign is_hlt  = (op == 3'b000);
  assign is_skz  = (op == 3'b001);
  assign is_sto  = (op == 3'b110);
  assign is_jmp  = (op == 3'b111);
  assign aluop   = (op == 3'b010) || (op == 3'b011) ||
                   (op == 3'b100) || (op == 3'b101);

  always_comb begin
    access = 1'b0;
    unique case (1'b1)
      (st == S1): access = 1'b1;
      (st == S5): access = aluop;
      (st == S7): access = aluop | is_sto;
      default:    access = 1'b0;
    endcase
  end

  assign stall = WAIT_EN && access && !mem_ready;
  assign nxt   = (st == S7) ? S0 : state_t'(st + 4'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      st   <= S0;
      cnt  <= 8'd0;
      to_q <= 1'b0;
      il_q <= 1'b0;
    end else begin
      unique case (st)
        HALTED: begin
          cnt <= 8'd0;
          if (resume) begin
            st   <= S0;
            to_q <= 1'b0;
            il_q <= 1'b0;
          end
        end
        S4: begin
          cnt <= 8'd0;
          st  <= is_hlt ? HALTED : S5;
          if (illegal) il_q <= 1'b1;
        end
        default: begin
          if (stall) begin
            if (cnt == 8'(MAX_WAIT)) begin
              st   <= HALTED;
              cnt  <= 8'd0;
              to_q <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            st  <= nxt;
            cnt <= 8'd0;
          end
        end
      endcase
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (1'b1)
      (st == S0): sel = 1'b1;
      (st == S1): begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      (st == S2), (st == S3): begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      (st == S4): begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      (st == S5): rd = aluop;
      (st == S6): begin
        rd     = aluop;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      (st == S7): begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      (st == HALTED): halt = 1'b1;
      default: ;
    endcase
  end

  assign phase       = (st != HALTED) && st[2];
  assign state       = st;
  assign err_timeout = to_q;
  assign err_illegal = il_q | ((st == S4) && illegal);

endmodule

// File: tb/tb_seq_controller.sv
// Directed vector bench for seq_controller (OPC_W=4, WAIT_EN=1,
// MAX_WAIT=3): table of per-edge vectors plus stall/halt sequences.
module tb_seq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       resume;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e;
  logic       halt, phase, err_timeout, err_illegal;
  logic [3:0] state;
  logic [11:0] outs;

  int checks = 0;
  int errors = 0;

  seq_controller #(
    .OPC_W    (4),
    .WAIT_EN  (1'b1),
    .MAX_WAIT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .resume      (resume),
    .sel         (sel),
    .rd          (rd),
    .wr          (wr),
    .ld_ir       (ld_ir),
    .ld_ac       (ld_ac),
    .ld_pc       (ld_pc),
    .inc_pc      (inc_pc),
    .data_e      (data_e),
    .halt        (halt),
    .phase       (phase),
    .state       (state),
    .err_timeout (err_timeout),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  // {sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,halt,phase,err_timeout,err_illegal}
  assign outs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e,
                 halt, phase, err_timeout, err_illegal};

  localparam logic [11:0] O_S0   = 12'b1000_0000_0000;
  localparam logic [11:0] O_S1   = 12'b1100_0000_0000;
  localparam logic [11:0] O_LD   = 12'b1101_0000_0000;
  localparam logic [11:0] O_S4   = 12'b0000_0010_0100;
  localparam logic [11:0] O_X    = 12'b0000_0000_0100;
  localparam logic [11:0] O_RD   = 12'b0100_0000_0100;
  localparam logic [11:0] O_ACC  = 12'b0100_1000_0100;
  localparam logic [11:0] O_INC  = 12'b0000_0010_0100;
  localparam logic [11:0] O_JMP  = 12'b0000_0100_0100;
  localparam logic [11:0] O_ST6  = 12'b0000_0001_0100;
  localparam logic [11:0] O_ST7  = 12'b0010_0001_0100;
  localparam logic [11:0] O_H4   = 12'b0000_0010_1100;
  localparam logic [11:0] O_HLTD = 12'b0000_0000_1000;
  localparam logic [11:0] O_HTO  = 12'b0000_0000_1010;
  localparam logic [11:0] O_IL4  = 12'b0000_0010_1101;
  localparam logic [11:0] O_HIL  = 12'b0000_0000_1001;

  typedef struct {
    logic       r;
    logic [3:0] opc;
    logic       z;
    logic       mr;
    logic       rs;
    logic [3:0] st;
    logic [11:0] o;
  } vec_t;

  vec_t tv [64];
  int   nv = 0;

  function automatic void add(logic r, logic [3:0] opc, logic z,
                              logic mr, logic rs, logic [3:0] st,
                              logic [11:0] o);
    tv[nv] = '{r: r, opc: opc, z: z, mr: mr, rs: rs, st: st, o: o};
    nv++;
  endfunction

  function automatic void add_instr(logic [3:0] opc, logic z, logic mr,
                                    logic [11:0] o4, logic [11:0] o5,
                                    logic [11:0] o6, logic [11:0] o7);
    add(1'b1, opc, z, mr,   1'b0, 4'd1, O_S1);
    add(1'b1, opc, z, 1'b1, 1'b0, 4'd2, O_LD);
    add(1'b1, opc, z, mr,   1'b0, 4'd3, O_LD);
    add(1'b1, opc, z, mr,   1'b0, 4'd4, o4);
    add(1'b1, opc, z, mr,   1'b0, 4'd5, o5);
    add(1'b1, opc, z, mr,   1'b0, 4'd6, o6);
    add(1'b1, opc, z, mr,   1'b0, 4'd7, o7);
    add(1'b1, opc, z, mr,   1'b0, 4'd0, O_S0);
  endfunction

  task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic [3:0] opc, logic z, logic mr,
                      logic rs);
    @(negedge clk);
    rst       = r;
    opcode    = opc;
    zero      = z;
    mem_ready = mr;
    resume    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_so(string nm, logic [3:0] st, logic [11:0] o);
    chk({nm, " state"}, {8'd0, state}, {8'd0, st});
    chk({nm, " outs"}, outs, o);
  endtask

  initial begin
    rst       = 1'b0;
    opcode    = 4'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    resume    = 1'b0;

    add(1'b0, 4'b0010, 1'b0, 1'b1, 1'b0, 4'd0, O_S0);
    add_instr(4'b0010, 1'b0, 1'b1, O_S4, O_RD, O_RD, O_ACC);
    add_instr(4'b0001, 1'b1, 1'b1, O_S4, O_X, O_INC, O_X);
    add_instr(4'b0001, 1'b0, 1'b1, O_S4, O_X, O_X, O_X);
    // mem_ready low outside access states must not stall JMP
    add_instr(4'b0111, 1'b0, 1'b0, O_S4, O_X, O_JMP, O_JMP);
    add_instr(4'b0110, 1'b0, 1'b1, O_S4, O_X, O_ST6, O_ST7);

    for (int i = 0; i < nv; i++) begin
      step(tv[i].r, tv[i].opc, tv[i].z, tv[i].mr, tv[i].rs);
      expect_so($sformatf("vec%0d", i), tv[i].st, tv[i].o);
    end

    // STO: 2 stalls in S1, then 3 stalls in S7 (counter must restart)
    step(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    expect_so("sto s1 hold", 4'd1, O_S1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
    expect_so("sto s7 entry", 4'd7, O_ST7);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
      expect_so($sformatf("sto s7 hold%0d", i), 4'd7, O_ST7);
    end
    step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
    expect_so("sto done", 4'd0, O_S0);

    // Timeout in S1: 4 cycles in S1, then HALTED with err_timeout
    step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
      expect_so($sformatf("to s1 hold%0d", i), 4'd1, O_S1);
    end
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    expect_so("to halted", 4'd8, O_HTO);
    step(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1);
    expect_so("to resume", 4'd0, O_S0);

    // HLT with resume asserted early (ignored outside HALTED)
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    expect_so("hlt s3", 4'd3, O_LD);
    step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_so("hlt s4", 4'd4, O_H4);
    step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_so("hlt halted", 4'd8, O_HLTD);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
      expect_so($sformatf("hlt wait%0d", i), 4'd8, O_HLTD);
    end
    step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b1);
    expect_so("hlt resume", 4'd0, O_S0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_so("hlt again", 4'd8, O_HLTD);
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    expect_so("hlt reset", 4'd0, O_S0);

    // Illegal widened opcode: halts, flag cleared by resume then reset
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 4'b1010, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
      expect_so($sformatf("ill%0d s4", pass), 4'd4, O_IL4);
      step(1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);
      expect_so($sformatf("ill%0d halted", pass), 4'd8, O_HIL);
      step(pass == 1 ? 1'b0 : 1'b1, 4'b1010, 1'b0, 1'b1, 1'b1);
      expect_so($sformatf("ill%0d clear", pass), 4'd0, O_S0);
    end

    // Reset mid-S6 of an ADD
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0);
    expect_so("add s6", 4'd6, O_RD);
    step(1'b0, 4'b0010, 1'b0, 1'b1, 1'b0);
    expect_so("s6 reset", 4'd0, O_S0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
